// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and reset-PC default for pc_sequencer.
// Defining PC_SEQ_HALT_EN adds the HALT state.
package pc_seq_pkg;

`ifdef PC_SEQ_HALT_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} pc_seq_state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE} pc_seq_state_t;
`endif

    localparam logic [15:0] PC_SEQ_RESET_PC = 16'h0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory req/ack, decoder valid/ready and branch redirect bundle.
interface pc_sequencer_if #(
    parameter int ADDR_W = 16
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;
    logic              instr_valid;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              branch_enable;
    logic [ADDR_W-1:0] branch_addr;
    logic              halted;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
        input  imem_ack, imem_rdata, instr_ready, branch_enable, branch_addr
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
        output imem_ack, imem_rdata, instr_ready, branch_enable, branch_addr
    );

endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, fetches over req/ack, issues over valid/ready, redirects on branch.
// Defining PC_SEQ_HALT_EN adds the halt input and HALT state; otherwise halted is tied low.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_SEQ_RESET_PC)
) (
    input logic            clk,
    input logic            reset,
`ifdef PC_SEQ_HALT_EN
    input logic            halt,
`endif
    pc_sequencer_if.master bus
);

    pc_seq_state_t     r_state, w_state_nx;
    logic [ADDR_W-1:0] r_pc, w_pc_nx;
    logic [ADDR_W-1:0] r_redirect, w_redirect_nx;
    logic [ADDR_W-1:0] r_instr_pc;
    logic [15:0]       r_instr;
    logic              r_kill, w_kill_nx;
    logic              r_req, r_valid;
    logic              w_load;

    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_kill_nx     = r_kill;
        w_redirect_nx = r_redirect;
        w_load        = 1'b0;
        case (r_state)
            S_IDLE: w_state_nx = S_FETCH;
            S_FETCH: begin
                // An ack that coincides with a branch, or that answers a killed request, is wrong-path.
                if (bus.imem_ack) begin
                    w_kill_nx  = 1'b0;
                    w_load     = !bus.branch_enable && !r_kill;
                    w_pc_nx    = bus.branch_enable ? bus.branch_addr :
                                 r_kill            ? r_redirect      : r_pc + ADDR_W'(1);
                    w_state_nx = w_load ? S_ISSUE : S_FETCH;
                end else if (bus.branch_enable) begin
                    w_kill_nx     = 1'b1;
                    w_redirect_nx = bus.branch_addr;
                end
            end
            S_ISSUE: begin
                w_pc_nx    = bus.branch_enable ? bus.branch_addr : r_pc;
                w_state_nx = (bus.branch_enable || bus.instr_ready) ? S_FETCH : S_ISSUE;
            end
`ifdef PC_SEQ_HALT_EN
            S_HALT: begin
                w_pc_nx    = bus.branch_enable ? bus.branch_addr : r_pc;
                w_state_nx = halt ? S_HALT : S_FETCH;
            end
`endif
            default: w_state_nx = S_IDLE;
        endcase
`ifdef PC_SEQ_HALT_EN
        // Halt waits for any outstanding ack; a loaded word is still issued first.
        if (halt && w_state_nx == S_FETCH && (r_state == S_IDLE || r_state == S_ISSUE || bus.imem_ack))
            w_state_nx = S_HALT;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_redirect <= RESET_PC;
            r_kill     <= 1'b0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_redirect <= w_redirect_nx;
            r_kill     <= w_kill_nx;
            r_req      <= w_state_nx == S_FETCH;
            r_valid    <= w_state_nx == S_ISSUE;
            if (w_load) begin
                r_instr    <= bus.imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

`ifdef PC_SEQ_HALT_EN
    logic r_halted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_halted <= 1'b0;
        else
            r_halted <= w_state_nx == S_HALT;
    end

    assign bus.halted = r_halted;
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan sequences plus randomized traffic against a transaction-level model.
module tb_pc_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   run   = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   handed   = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(16)) bus ();

    pc_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef PC_SEQ_HALT_EN
        .halt  (1'b0),
`endif
        .bus   (bus)
    );

    // Model: whether a fetch or a held word is pending, plus the list of redirects seen while a fetch was in flight.
    bit          m_started, m_req, m_valid;
    logic [15:0] m_pc, m_instr, m_ipc;
    logic [15:0] q[$];

    function automatic logic [15:0] word_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_req     = 1'b0;
        m_valid   = 1'b0;
        m_pc      = 16'h0000;
        m_instr   = 16'h0000;
        m_ipc     = 16'h0000;
        q.delete();
    endtask

    task automatic model_step();
        if (!m_started) begin
            m_started = 1'b1;
            m_req     = 1'b1;
        end else if (m_req) begin
            if (bus.imem_ack) begin
                if (bus.branch_enable || q.size() != 0) begin
                    m_pc = bus.branch_enable ? bus.branch_addr : q[$];
                    q.delete();
                end else begin
                    m_instr = bus.imem_rdata;
                    m_ipc   = m_pc;
                    m_pc    = m_pc + 16'd1;
                    m_req   = 1'b0;
                    m_valid = 1'b1;
                end
            end else if (bus.branch_enable) begin
                q.push_back(bus.branch_addr);
            end
        end else if (m_valid && (bus.branch_enable || bus.instr_ready)) begin
            if (bus.branch_enable)
                m_pc = bus.branch_addr;
            else
                handed++;
            m_valid = 1'b0;
            m_req   = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit a, input bit r, input bit b, input logic [15:0] ba);
        bus.imem_ack      = a && bus.imem_req;
        bus.imem_rdata    = word_of(bus.imem_addr);
        bus.instr_ready   = r;
        bus.branch_enable = b;
        bus.branch_addr   = ba;
    endtask

    always @(negedge clk) begin
        if (run && !reset) begin
            chk("req", 16'(bus.imem_req), 16'(m_req));
            if (m_req) chk("addr", bus.imem_addr, m_pc);
            chk("valid", 16'(bus.instr_valid), 16'(m_valid));
            if (m_valid) begin
                chk("instr", bus.instr, m_instr);
                chk("instr_pc", bus.instr_pc, m_ipc);
                chk("instr_data", bus.instr, word_of(bus.instr_pc));
            end
            chk("halted", 16'(bus.halted), 16'h0);
        end
    end

    initial begin
        drive(0, 0, 0, 16'h0);
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req", 16'(bus.imem_req), 16'h0);
        chk("rst_addr", bus.imem_addr, 16'h0000);
        chk("rst_valid", 16'(bus.instr_valid), 16'h0);
        chk("rst_instr", bus.instr, 16'h0000);
        chk("rst_instr_pc", bus.instr_pc, 16'h0000);
        reset = 1'b0;
        run   = 1'b1;
        // Zero-wait ack with ready held high: one word every two cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_req", 16'(bus.imem_req), 16'h1);
            chk("t1_addr", bus.imem_addr, 16'(i));
            chk("t1_valid_low", 16'(bus.instr_valid), 16'h0);
            drive(1, 1, 0, 16'h0);
            tick();
            chk("t1_valid", 16'(bus.instr_valid), 16'h1);
            chk("t1_instr_pc", bus.instr_pc, 16'(i));
            drive(1, 1, 0, 16'h0);
        end
        // Ack delayed three cycles, then ready withheld for four.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_req", 16'(bus.imem_req), 16'h1);
            chk("t2_addr", bus.imem_addr, 16'h0003);
            drive(i == 3, 0, 0, 16'h0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", 16'(bus.instr_valid), 16'h1);
            chk("t2_hold_pc", bus.instr_pc, 16'h0003);
            chk("t2_no_req", 16'(bus.imem_req), 16'h0);
            drive(0, i == 4, 0, 16'h0);
        end
        tick();
        chk("t2_next_addr", bus.imem_addr, 16'h0004);
        drive(1, 0, 0, 16'h0);
        // Branch in ISSUE together with ready: held word discarded.
        tick();
        chk("t3_valid", 16'(bus.instr_valid), 16'h1);
        drive(0, 1, 1, 16'h0040);
        tick();
        chk("t3_addr", bus.imem_addr, 16'h0040);
        chk("t3_valid_low", 16'(bus.instr_valid), 16'h0);
        drive(1, 0, 1, 16'h0005);
        // Branch during an outstanding fetch of 0x0005, ack two cycles later.
        tick();
        chk("t4_addr", bus.imem_addr, 16'h0005);
        drive(0, 0, 1, 16'h0080);
        tick();
        chk("t4_hold_addr", bus.imem_addr, 16'h0005);
        drive(0, 0, 0, 16'h0);
        tick();
        chk("t4_hold_addr2", bus.imem_addr, 16'h0005);
        drive(1, 0, 0, 16'h0);
        tick();
        chk("t4_dropped", 16'(bus.instr_valid), 16'h0);
        chk("t4_req", 16'(bus.imem_req), 16'h1);
        chk("t4_new_addr", bus.imem_addr, 16'h0080);
        drive(1, 0, 1, 16'hFFFF);
        // PC wrap from 0xFFFF.
        tick();
        chk("t5_addr", bus.imem_addr, 16'hFFFF);
        drive(1, 0, 0, 16'h0);
        tick();
        chk("t5_instr_pc", bus.instr_pc, 16'hFFFF);
        drive(0, 1, 0, 16'h0);
        tick();
        chk("t5_wrap", bus.imem_addr, 16'h0000);
        drive(1, 0, 1, 16'h0123);
        tick();
        chk("t6_addr", bus.imem_addr, 16'h0123);
        drive(0, 0, 0, 16'h0);
        // Asynchronous reset mid-fetch.
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("t6_req_async", 16'(bus.imem_req), 16'h0);
        chk("t6_valid_async", 16'(bus.instr_valid), 16'h0);
        chk("t6_addr_async", bus.imem_addr, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("t6_restart", bus.imem_addr, 16'h0000);
        chk("t6_restart_req", 16'(bus.imem_req), 16'h1);
        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 4) < 3, $urandom_range(0, 11) == 0,
                  ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom));
            tick();
        end
        chk("rand_progress", 16'(handed > 100), 16'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
